star_pixel_scanner: RTL and testbench
=====================================

# star_pixel_scanner

Raster-order reader for the 160x120 image memory that the box drawer and VGA path write. It issues read addresses and compares each returned pixel against background (0) and the box colour. It stops on the first star pixel, presents that pixel's coordinates with a hold-until-acknowledged handshake, and resumes from the next pixel on request. Its coordinate outputs seed the top/bottom mapper; `scanDone` tells the master FSM that the frame has no further stars.

## Interface
- `xSz`, 8, x coordinate width
- `ySz`, 7, y coordinate width
- `colSz`, 3, pixel colour width
- `XMAX`, 160, pixels per row
- `YMAX`, 120, rows per frame
- `BOX_COL`, 3'b010, colour written by the box drawer; never reported as a star

- `clk`  in  1  single system clock, rising edge
- `resetn`  in  1  reset, asynchronous, active-low
- `go`  in  1  level start; sampled only in IDLE
- `resume`  in  1  acknowledge of reported star; sampled only in FOUND
- `pixVal`  in  colSz  read data for the address presented the previous cycle (memory latency fixed at 1)
- `rdAddress`  out  15  read address = y*XMAX + x
- `xOut`  out  xSz  x of reported star
- `yOut`  out  ySz  y of reported star
- `starFound`  out  1  high while a star is reported (FOUND state)
- `scanDone`  out  1  high in DONE
- `busy`  out  1  high in SCAN or FOUND

## Operation
- Registers:
  - issue counters `xc`/`yc` plus an `issuing` flag
  - pipeline tag `xp`/`yp`/`vld`, giving the coordinates of the address issued last cycle
  - output registers `xOut`/`yOut`
- Address generation:
  - `rdAddress` = (yc<<7)+(yc<<5)+xc, zero-extended to 15 bits. Maximum value is 19199, so no overflow.
  - The address is driven from the registered counters in every state.
- Hit condition: `vld` && `pixVal` != 0 && `pixVal` != BOX_COL.
- States: IDLE, SCAN, FOUND, DONE.
- **IDLE**
  - Counters are 0, `vld`=0, `issuing`=0.
  - `go`=1 at a clock edge moves to SCAN with `issuing`=1.
- **SCAN**
  - Each cycle where `issuing`=1: the tag takes (xc,yc) with `vld`=1, then the counters advance in raster order (xc wraps XMAX-1→0 and increments yc).
  - Issuing (159,119) clears `issuing`. The counters then hold, and `vld` is cleared the following cycle.
  - On a hit: latch `xOut`=xp, `yOut`=yp, load the counters with the raster successor of (xp,yp), clear `vld`, and go to FOUND.
    - If (xp,yp) = (XMAX-1,YMAX-1), also clear `issuing`.
    - The speculative read issued in the hit cycle is discarded.
  - `vld`=1 with no hit while `issuing`=0 (the last pixel was checked) goes to DONE.
  - `go` and `resume` are ignored.
- **FOUND**
  - `starFound`=1; `xOut`/`yOut` are stable.
  - `resume`=1 with `issuing`=1 goes to SCAN.
  - `resume`=1 with `issuing`=0 goes to DONE.
- **DONE**
  - `scanDone`=1.
  - `go`=0 returns to IDLE, so a new scan needs `go` to be deasserted and then reasserted.
- Reset, asynchronous at any time, including mid-scan or in FOUND:
  - state IDLE; all counters, tags and flags 0
  - `xOut`=0, `yOut`=0, `rdAddress`=0
  - `starFound`=0, `scanDone`=0, `busy`=0
- `go` dropping mid-scan has no effect.

## Timing
- Let cycle 0 be the first SCAN cycle.
  - The address of pixel index p (= y*160+x) is presented in cycle p.
  - Its data is checked in cycle p+1.
- Star at index p:
  - FOUND is registered at the edge ending cycle p+1.
  - `starFound`, `xOut` and `yOut` are valid from cycle p+2 until the edge at which `resume` is sampled high.
- After resume:
  - SCAN is re-entered the next cycle and issues index p+1 in that cycle.
  - The next check happens one cycle later; there are no gaps or repeats.
- No star:
  - Index 19199 is checked in cycle 19200.
  - `scanDone` is high from cycle 19201.
- `starFound` falls in the cycle after `resume` is sampled.
- Holding `resume` high continuously acknowledges each subsequent star one cycle after it is reported.
- Throughput is 1 pixel/clock while scanning.
- Outputs are registered or derived from state only; no combinational path from `pixVal` to any output.

## Test plan
- All-zero image, `go`=1 → `starFound` never asserts; `rdAddress` sweeps 0..19199 one per clock; `scanDone`=1 from cycle 19201; `go`=0 → IDLE, `busy`=0.
- Single pixel colour 3'b111 at (10,5), index 810 → `starFound` high from cycle 812 with `xOut`=10, `yOut`=5, held for 20 cycles of `resume`=0. Assert `resume` → scan continues from index 811 and `scanDone` rises.
- Adjacent stars at (3,0) and (4,0), `resume` tied high → two `starFound` reports with coordinates (3,0) then (4,0); no pixel skipped or reported twice.
- Image containing only BOX_COL pixels plus one star at (159,119) → box pixels ignored; report (159,119); `resume` goes directly to DONE with no further addresses checked.
- Assert `resetn`=0 mid-scan at index 5000 and while in FOUND → all outputs 0 immediately. Release with `go`=1 → scan restarts at address 0.
- Toggle `go` during SCAN and pulse `resume` during SCAN → no effect on address sequence or results.

Source files
------------

// File: rtl/star_pixel_scanner.sv
`default_nettype none
// ============================================================================
// Module   : star_pixel_scanner
// Purpose  : Raster-order reader of the 160x120 frame store; stops on each
//            pixel that is neither background nor box colour and reports it.
// Revision : 1.0  initial release
// ============================================================================
module star_pixel_scanner #(
  parameter int              xSz     = 8,
  parameter int              ySz     = 7,
  parameter int              colSz   = 3,
  parameter int              XMAX    = 160,
  parameter int              YMAX    = 120,
  parameter logic [colSz-1:0] BOX_COL = 3'b010
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic             resume,
  input  logic [colSz-1:0] pixVal,
  output logic [14:0]      rdAddress,
  output logic [xSz-1:0]   xOut,
  output logic [ySz-1:0]   yOut,
  output logic             starFound,
  output logic             scanDone,
  output logic             busy
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SCAN  = 2'd1;
  localparam logic [1:0] c_FOUND = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [xSz-1:0] c_XLAST = xSz'(XMAX - 1);
  localparam logic [ySz-1:0] c_YLAST = ySz'(YMAX - 1);

  logic [1:0]     r_state;
  logic [1:0]     w_nextState;

  // Issue counters: address being presented this cycle
  logic [xSz-1:0] r_xc;
  logic [ySz-1:0] r_yc;
  logic           r_issuing;

  // Pipeline tag: coordinates whose data arrives on pixVal this cycle
  logic [xSz-1:0] r_xp;
  logic [ySz-1:0] r_yp;
  logic           r_vld;

  logic           w_hit;
  logic           w_issueLast;
  logic           w_tagLast;
  logic [xSz-1:0] w_advX;
  logic [ySz-1:0] w_advY;
  logic [xSz-1:0] w_succX;
  logic [ySz-1:0] w_succY;
  logic [14:0]    w_yExt;

  assign w_hit = (r_state == c_SCAN) && r_vld &&
                 (pixVal != '0) && (pixVal != BOX_COL);

  assign w_issueLast = (r_xc == c_XLAST) && (r_yc == c_YLAST);
  assign w_tagLast   = (r_xp == c_XLAST) && (r_yp == c_YLAST);

  assign w_advX  = (r_xc == c_XLAST) ? '0 : r_xc + xSz'(1);
  assign w_advY  = (r_xc == c_XLAST) ? r_yc + ySz'(1) : r_yc;
  assign w_succX = (r_xp == c_XLAST) ? '0 : r_xp + xSz'(1);
  assign w_succY = (r_xp == c_XLAST) ? r_yp + ySz'(1) : r_yp;

  // y*160 built as y*128 + y*32; peaks at 19199 so 15 bits never overflow
  assign w_yExt    = 15'(r_yc);
  assign rdAddress = (w_yExt << 7) + (w_yExt << 5) + 15'(r_xc);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      c_IDLE: begin
        if (go) begin
          w_nextState = c_SCAN;
        end
      end
      c_SCAN: begin
        if (w_hit) begin
          w_nextState = c_FOUND;
        end else if (r_vld && !r_issuing) begin
          w_nextState = c_DONE;
        end
      end
      c_FOUND: begin
        if (resume) begin
          w_nextState = r_issuing ? c_SCAN : c_DONE;
        end
      end
      c_DONE: begin
        if (!go) begin
          w_nextState = c_IDLE;
        end
      end
      default: w_nextState = c_IDLE;
    endcase
  end

  always_comb begin
    starFound = 1'b0;
    scanDone  = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      c_SCAN:  busy = 1'b1;
      c_FOUND: begin
        busy      = 1'b1;
        starFound = 1'b1;
      end
      c_DONE:  scanDone = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_xc      <= '0;
      r_yc      <= '0;
      r_issuing <= 1'b0;
      r_xp      <= '0;
      r_yp      <= '0;
      r_vld     <= 1'b0;
      xOut      <= '0;
      yOut      <= '0;
    end else begin
      unique case (r_state)
        c_IDLE: begin
          r_xc      <= '0;
          r_yc      <= '0;
          r_vld     <= 1'b0;
          r_issuing <= go;
        end
        c_SCAN: begin
          if (w_hit) begin
            // Rewind to the pixel after the star; the read issued now is dropped
            xOut  <= r_xp;
            yOut  <= r_yp;
            r_vld <= 1'b0;
            if (w_tagLast) begin
              r_issuing <= 1'b0;
            end else begin
              r_xc      <= w_succX;
              r_yc      <= w_succY;
              r_issuing <= 1'b1;
            end
          end else if (r_issuing) begin
            r_xp  <= r_xc;
            r_yp  <= r_yc;
            r_vld <= 1'b1;
            if (w_issueLast) begin
              r_issuing <= 1'b0;
            end else begin
              r_xc <= w_advX;
              r_yc <= w_advY;
            end
          end else begin
            r_vld <= 1'b0;
          end
        end
        c_FOUND: begin
          r_vld <= 1'b0;
        end
        c_DONE: begin
          if (!go) begin
            r_xc      <= '0;
            r_yc      <= '0;
            r_issuing <= 1'b0;
            r_vld     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_star_pixel_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_star_pixel_scanner
// Purpose  : Random frame images; expected star reports queued from the image,
//            monitor compares each report, its timing and the address sweep.
// Revision : 1.0  initial release
// ============================================================================
module tb_star_pixel_scanner;

  localparam int NPIX = 19200;
  localparam int BOX  = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        go;
  logic        resume;
  logic [2:0]  pixVal;
  logic [14:0] rdAddress;
  logic [7:0]  xOut;
  logic [6:0]  yOut;
  logic        starFound;
  logic        scanDone;
  logic        busy;

  always #5 clk = ~clk;

  star_pixel_scanner dut (
    .clk       (clk),
    .resetn    (resetn),
    .go        (go),
    .resume    (resume),
    .pixVal    (pixVal),
    .rdAddress (rdAddress),
    .xOut      (xOut),
    .yOut      (yOut),
    .starFound (starFound),
    .scanDone  (scanDone),
    .busy      (busy)
  );

  logic [2:0] img [NPIX];
  logic [2:0] starCols [6] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  int  expQ[$];
  int  nTests = 0;
  int  nFail  = 0;
  int  gcyc   = 0;
  int  startCyc = 0;
  bit  scanActive = 1'b0;
  bit  doneSeen   = 1'b0;

  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic checkEq(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame store with one cycle of read latency
  initial begin : memModel
    int a;
    pixVal = '0;
    forever begin
      @(negedge clk);
      a = int'(rdAddress);
      @(posedge clk);
      #1;
      pixVal = (a < NPIX) ? img[a] : 3'd0;
    end
  end

  // Scoreboard monitor: report order/position, handshake, address sweep, end of frame
  initial begin : monitor
    int  off, curP, lastP, F, n, expA, seqBad, badN, badA, badE;
    bit  prevSF, prevRes, inited;
    inited = 1'b0;
    forever begin
      @(negedge clk);
      if (!scanActive) begin
        inited = 1'b0;
        continue;
      end
      if (!inited) begin
        inited = 1'b1;
        off = 0; curP = -1; lastP = -1; F = 0; seqBad = 0; badN = -1; badA = 0; badE = 0;
        prevSF = 1'b0; prevRes = 1'b0;
      end
      n = gcyc - startCyc;
      if (n >= 0 && !doneSeen) begin
        if (starFound && !prevSF) begin
          if (expQ.size() == 0) begin
            checkEq("extra-star-index", int'(yOut) * 160 + int'(xOut), -1);
            curP = -1;
          end else begin
            curP = expQ.pop_front();
            checkEq("star-time", n, curP + 2 + off);
            checkEq("star-x", int'(xOut), curP % 160);
            checkEq("star-y", int'(yOut), curP / 160);
          end
          lastP = curP;
          F = 1;
        end else if (starFound) begin
          F++;
          if (prevRes || int'(xOut) != curP % 160 || int'(yOut) != curP / 160) seqBad++;
        end else if (prevSF) begin
          checkEq("resume-ack", int'(prevRes), 1);
          off += F + 1;
        end

        if (scanDone) begin
          doneSeen = 1'b1;
          checkEq("done-time", n, (lastP == NPIX - 1) ? NPIX + off : NPIX + 1 + off);
          checkEq("stars-unreported", expQ.size(), 0);
          if (badN >= 0)
            $display("  first deviation at cycle %0d: rdAddress %0d expected %0d", badN, badA, badE);
          checkEq("sequence-deviations", seqBad, 0);
        end else begin
          if (starFound) expA = (curP + 1 > NPIX - 1) ? NPIX - 1 : curP + 1;
          else           expA = (n - off > NPIX - 1) ? NPIX - 1 : n - off;
          if (!busy || int'(rdAddress) != expA) begin
            seqBad++;
            if (badN < 0) begin
              badN = n; badA = int'(rdAddress); badE = expA;
            end
          end
        end
      end
      prevSF  = starFound;
      prevRes = resume;
    end
  end

  function automatic int pickHold(input int mode, input int idx);
    if (mode == 1 && idx < 2) return 0;
    if (mode == 1 && idx == 2) return 20;
    return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 25));
  endfunction

  task automatic buildExp();
    expQ.delete();
    for (int p = 0; p < NPIX; p++)
      if (img[p] != 3'd0 && img[p] != 3'(BOX)) expQ.push_back(p);
  endtask

  task automatic runScan(input string tag, input int holdMode);
    int hold, repIdx;
    bit pSF;
    buildExp();
    @(posedge clk);
    #1;
    go = 1'b1; resume = 1'b0; doneSeen = 1'b0;
    startCyc = gcyc + 1;
    scanActive = 1'b1;
    hold = 0; repIdx = 0; pSF = 1'b0;
    for (int i = 0; i < 30000 && !doneSeen; i++) begin
      @(posedge clk);
      #1;
      if (starFound) begin
        if (!pSF) begin
          hold = pickHold(holdMode, repIdx);
          repIdx++;
        end
        if (hold == 0) resume = 1'b1;
        else begin
          resume = 1'b0;
          hold--;
        end
      end else begin
        resume = ($urandom_range(0, 4) == 0);
      end
      pSF = starFound;
      go  = busy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    checkEq({tag, "-finished"}, int'(doneSeen), 1);
    go = 1'b0; resume = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkEq({tag, "-idle-busy"}, int'(busy), 0);
    checkEq({tag, "-idle-done"}, int'(scanDone), 0);
    scanActive = 1'b0;
  endtask

  task automatic resetTest();
    int n;
    for (int p = 0; p < NPIX; p++) img[p] = 3'd0;
    img[6000] = 3'd5;
    @(posedge clk);
    #1;
    go = 1'b1; resume = 1'b0;
    startCyc = gcyc + 1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (gcyc - startCyc >= 5000) break;
    end
    checkEq("rst-pre-addr", int'(rdAddress), 5000);
    #2 resetn = 1'b0;
    #1;
    checkEq("rst-scan-addr", int'(rdAddress), 0);
    checkEq("rst-scan-xy", int'({xOut, yOut}), 0);
    checkEq("rst-scan-flags", int'({starFound, scanDone, busy}), 0);
    @(negedge clk);
    resetn = 1'b1;
    startCyc = gcyc + 1;
    @(negedge clk);
    checkEq("restart-addr0", int'(rdAddress), 0);
    @(negedge clk);
    checkEq("restart-addr1", int'(rdAddress), 1);
    n = -1;
    for (int i = 0; i < 7000; i++) begin
      @(negedge clk);
      if (starFound) begin
        n = gcyc - startCyc;
        break;
      end
    end
    checkEq("rst-star-time", n, 6002);
    checkEq("rst-star-x", int'(xOut), 80);
    checkEq("rst-star-y", int'(yOut), 37);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checkEq("rst-found-xy", int'({xOut, yOut}), 0);
    checkEq("rst-found-flags", int'({starFound, scanDone, busy}), 0);
    go = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checkEq("rst-idle-busy", int'(busy), 0);
    checkEq("rst-idle-addr", int'(rdAddress), 0);
  endtask

  initial begin : stimulus
    int r;
    for (int p = 0; p < NPIX; p++) img[p] = 3'd0;
    resetn = 1'b0; go = 1'b0; resume = 1'b0;
    repeat (2) @(negedge clk);
    checkEq("reset-addr", int'(rdAddress), 0);
    checkEq("reset-x", int'(xOut), 0);
    checkEq("reset-y", int'(yOut), 0);
    checkEq("reset-starFound", int'(starFound), 0);
    checkEq("reset-scanDone", int'(scanDone), 0);
    checkEq("reset-busy", int'(busy), 0);
    resetn = 1'b1;

    // Empty frame, go/resume noise during the sweep
    runScan("empty", 0);

    // Box colour background, fixed stars at (3,0),(4,0),(10,5),(159,119), sparse random stars
    for (int p = 0; p < NPIX; p++) begin
      r = int'($urandom_range(0, 999));
      if (r < 120) img[p] = 3'(BOX);
      else if (r < 121 && p >= 1000) img[p] = starCols[$urandom_range(0, 5)];
      else img[p] = 3'd0;
    end
    img[3] = 3'd5; img[4] = 3'd1; img[810] = 3'd7; img[NPIX - 1] = 3'd6;
    runScan("mixed", 1);

    resetTest();

    // Dense random frame
    for (int p = 0; p < NPIX; p++) begin
      r = int'($urandom_range(0, 299));
      if (r == 0) img[p] = starCols[$urandom_range(0, 5)];
      else if (r < 75) img[p] = 3'(BOX);
      else img[p] = 3'd0;
    end
    runScan("dense", 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
